// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, reads imem combinationally, loads IF/ID one edge later.
// Latency 1 cycle; stall freezes PC and IF/ID, redirect overrides stall, halt word parks fetch until redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pcplus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic {RUN, HALT} stateT;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifIdT;

  localparam ifIdT BUBBLE = '{instr: NOP_WORD, pcPlus4: 32'h0, valid: 1'b0};

  stateT       state;
  ifIdT        ifId;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] count;

  assign pcPlus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= {RESET_PC[31:2], 2'b00};
      ifId   <= BUBBLE;
      count  <= 32'h0;
      halted <= 1'b0;
    end else if (redirect) begin
      // A redirect squashes whatever is stalled and also releases a halt.
      state  <= RUN;
      pc     <= {redirect_pc[31:2], 2'b00};
      ifId   <= BUBBLE;
      halted <= 1'b0;
    end else if (state == RUN && !stall) begin
      if (imem_data == HALT_WORD) begin
        state  <= HALT;
        ifId   <= BUBBLE;
        halted <= 1'b1;
      end else begin
        pc    <= pcPlus4;
        ifId  <= '{instr: imem_data, pcPlus4: pcPlus4, valid: 1'b1};
        count <= count + 32'd1;
      end
    end
  end

  assign imem_addr     = pc;
  assign if_id_instr   = ifId.instr;
  assign if_id_pcplus4 = ifId.pcPlus4;
  assign if_id_valid   = ifId.valid;
  assign instr_count   = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns addr+0x2400_0000, or the halt word at a chosen address.
module tb_fetch_stage;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] OFS       = 32'h2400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pcplus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] instr_count;

  logic        haltEn;
  logic [31:0] haltAddr;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pcplus4(if_id_pcplus4), .if_id_valid(if_id_valid),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_data = imem_addr + OFS;
    if (haltEn && imem_addr == haltAddr) imem_data = HALT_WORD;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic vld, input logic [31:0] cnt,
                          input logic hlt);
    chk({tag, ".pc"}, imem_addr, pc);
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".pcplus4"}, if_id_pcplus4, p4);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, vld});
    chk({tag, ".count"}, instr_count, cnt);
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, hlt});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    haltEn = 1'b0; haltAddr = 32'h0;
    step();
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);

    rst = 1'b0;
    step();
    checkAll("fetch1", 32'h04, OFS + 32'h00, 32'h04, 1'b1, 32'd1, 1'b0);
    step();
    checkAll("fetch2", 32'h08, OFS + 32'h04, 32'h08, 1'b1, 32'd2, 1'b0);

    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checkAll("stall", 32'h08, OFS + 32'h04, 32'h08, 1'b1, 32'd2, 1'b0);
    end
    stall = 1'b0;
    step();
    checkAll("release", 32'h0C, OFS + 32'h08, 32'h0C, 1'b1, 32'd3, 1'b0);
    step();
    checkAll("fetch4", 32'h10, OFS + 32'h0C, 32'h10, 1'b1, 32'd4, 1'b0);

    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    checkAll("redir", 32'h100, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0);
    redirect = 1'b0;
    step();
    checkAll("target", 32'h104, OFS + 32'h100, 32'h104, 1'b1, 32'd5, 1'b0);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0020;
    step();
    checkAll("redirStall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5, 1'b0);

    redirect = 1'b0; stall = 1'b0; haltEn = 1'b1; haltAddr = 32'h20;
    step();
    checkAll("haltEntry", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      step();
      checkAll("haltHold", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5, 1'b1);
    end

    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    checkAll("haltExit", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5, 1'b0);
    redirect = 1'b0;
    step();
    checkAll("afterHalt", 32'h44, OFS + 32'h40, 32'h44, 1'b1, 32'd6, 1'b0);

    haltEn = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    checkAll("redirTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd6, 1'b0);
    redirect = 1'b0;
    step();
    checkAll("wrap", 32'h0, OFS + 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd7, 1'b0);
    step();
    checkAll("postWrap", 32'h04, OFS + 32'h0, 32'h04, 1'b1, 32'd8, 1'b0);

    rst = 1'b1; stall = 1'b1;
    step();
    checkAll("midReset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step();
    checkAll("afterReset", 32'h04, OFS + 32'h00, 32'h04, 1'b1, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the combinational instruction memory, and loads the IF/ID pipeline register that feeds decode and the control unit. It also handles:
- load-use stalls from the hazard logic;
- taken-branch/jump redirects resolved downstream;
- a halt opcode that parks the front end.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFC00_0000, instruction word (opcode 6'b111111, rest zero) that halts fetch.
- NOP_WORD, 32'h0000_0000, bubble injected into IF/ID on flush/halt.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- imem_addr  out  32  read address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word; combinational read of imem_addr.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect  in  1  taken branch or jump; replace PC, flush IF/ID.
- redirect_pc  in  32  target address; bits [1:0] ignored (forced to 00).
- if_id_instr  out  32  registered instruction to decode.
- if_id_pcplus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real instruction, 0 = bubble.
- halted  out  1  1 while in HALT state.
- instr_count  out  32  number of instructions accepted into IF/ID.

## Operation
- Reset (rst=1 at an edge), which takes priority over everything and applies equally mid-operation:
  - pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pcplus4=0, if_id_valid=0;
  - halted=0, instr_count=0, state=RUN.
- States: RUN and HALT. Priority per edge: rst > redirect > stall > normal fetch.
- RUN, redirect=1 (stall ignored, since the redirect squashes the stalled instruction):
  - pc<={redirect_pc[31:2],2'b00};
  - IF/ID <= NOP_WORD with valid=0, pcplus4=0;
  - count unchanged.
- RUN, stall=1, redirect=0: pc, IF/ID and count hold their values.
- RUN, normal fetch, imem_data!=HALT_WORD:
  - pc<=pc+4;
  - if_id_instr<=imem_data, if_id_pcplus4<=pc+4, valid=1;
  - instr_count<=instr_count+1.
- RUN, normal fetch, imem_data==HALT_WORD:
  - state<=HALT, pc holds at the halt address;
  - IF/ID <= NOP_WORD with valid=0; count unchanged.
  - The halt word is never passed to decode.
- HALT, redirect=1: state<=RUN and the redirect is applied exactly as in RUN. This covers a branch older than the halt that is still in flight.
- HALT, otherwise: pc holds, IF/ID stays bubble (valid=0), stall has no effect.
- halted is 1 exactly when state==HALT.
- Arithmetic:
  - pc+4 and instr_count are 32-bit modulo (0xFFFF_FFFC+4 wraps to 0; count wraps 0xFFFF_FFFF to 0).
  - pc[1:0] is always 00.
- Only IF/ID is flushed here. ID/EX and later flushing on redirect belongs to the hazard unit.

## Timing
- imem_addr is a direct register output with no combinational path from any input. imem_data is sampled in the same cycle.
- Fetch latency: the instruction at PC=A appears on if_id_instr the cycle after imem_addr=A, with pcplus4=A+4.
- Throughput is one instruction per cycle when stall=0 and redirect=0.
- Redirect: at the asserting edge, pc takes the target and IF/ID becomes a bubble. The target instruction is in IF/ID one edge later.
  - Penalty: one bubble out of this stage.
- Stall: all outputs are frozen for every cycle stall=1. Fetch resumes on the first edge with stall=0.
- HALT entry is visible on halted the edge after the halt word is on imem_data.
- Reset takes effect on the first rising edge with rst=1. The first valid IF/ID is one edge after rst drops.

## Test plan
- Reset then free-run, with imem returning addr-based words: after 3 edges post-reset, pc=0x0C, if_id_pcplus4=0x0C, instr_count=3, valid=1.
- Stall held 2 cycles at pc=0x08: pc, if_id_instr and count unchanged for both cycles; on release the next edge gives pc=0x0C and count+1.
- Redirect with redirect_pc=0x0000_0103 at pc=0x10: next edge gives pc=0x100, valid=0, instr_count unchanged. The edge after that gives if_id_pcplus4=0x104.
- Redirect and stall asserted together: redirect wins, pc=target, IF/ID becomes a bubble.
- imem returns HALT_WORD at pc=0x20:
  - halted=1, pc stays 0x20, valid=0 indefinitely, count frozen;
  - then redirect to 0x40: halted=0 and pc=0x40 on the same edge.
- Wrap-around and reset:
  - redirect to 0xFFFF_FFFC then free-run: pc wraps to 0, if_id_pcplus4=0.
  - rst pulsed mid-stream with stall=1: all outputs return to their reset values on that edge.
